// File: rtl/apb5_requester.sv
`default_nettype none
// ============================================================================
// apb5_requester: valid/ready command channel to APB5 SETUP/ACCESS transfers,
// with PWAKEUP lead-time sequencing and an optional wait-state timeout.
// Revision: 1.0
// ============================================================================
module apb5_requester #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int USER_REQ_WIDTH  = 1,
    parameter int USER_DATA_WIDTH = 1,
    parameter int USER_RESP_WIDTH = 1,
    parameter int WAKEUP_LEAD     = 1,
    parameter int TIMEOUT_CYCLES  = 256
) (
    input  logic                         pclk,
    input  logic                         presetn,

    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic                         cmd_write,
    input  logic [ADDR_WIDTH-1:0]        cmd_addr,
    input  logic [DATA_WIDTH-1:0]        cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0]      cmd_strb,
    input  logic [2:0]                   cmd_prot,
    input  logic [USER_REQ_WIDTH-1:0]    cmd_auser,
    input  logic [USER_DATA_WIDTH-1:0]   cmd_wuser,

    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [DATA_WIDTH-1:0]        rsp_rdata,
    output logic                         rsp_err,
    output logic                         rsp_timeout,
    output logic [USER_DATA_WIDTH-1:0]   rsp_ruser,
    output logic [USER_RESP_WIDTH-1:0]   rsp_buser,

    output logic [ADDR_WIDTH-1:0]        paddr,
    output logic [2:0]                   pprot,
    output logic                         psel,
    output logic                         penable,
    output logic                         pwrite,
    output logic [DATA_WIDTH-1:0]        pwdata,
    output logic [DATA_WIDTH/8-1:0]      pstrb,
    output logic                         pwakeup,
    output logic [USER_REQ_WIDTH-1:0]    pauser,
    output logic [USER_DATA_WIDTH-1:0]   pwuser,
    input  logic                         pready,
    input  logic [DATA_WIDTH-1:0]        prdata,
    input  logic                         pslverr,
    input  logic [USER_DATA_WIDTH-1:0]   pruser,
    input  logic [USER_RESP_WIDTH-1:0]   pbuser
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int WAIT_W     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int LEAD_W     = (WAKEUP_LEAD > 0) ? $clog2(WAKEUP_LEAD + 1) : 1;

    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = {WAIT_W{1'b1}};
    localparam logic [LEAD_W-1:0] LEAD_ONE  = LEAD_W'(1);
    localparam logic [LEAD_W-1:0] LEAD_LAST = LEAD_W'(WAKEUP_LEAD);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAKE   = 3'd1,
        S_SETUP  = 3'd2,
        S_ACCESS = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    state_t                       state_q,       state_d;
    logic [LEAD_W-1:0]            lead_cnt_q,    lead_cnt_d;
    logic [WAIT_W-1:0]            wait_cnt_q,    wait_cnt_d;
    logic [WAIT_W-1:0]            wait_inc;

    logic [ADDR_WIDTH-1:0]        addr_q,        addr_d;
    logic [2:0]                   prot_q,        prot_d;
    logic                         write_q,       write_d;
    logic [DATA_WIDTH-1:0]        wdata_q,       wdata_d;
    logic [STRB_WIDTH-1:0]        strb_q,        strb_d;
    logic [USER_REQ_WIDTH-1:0]    auser_q,       auser_d;
    logic [USER_DATA_WIDTH-1:0]   wuser_q,       wuser_d;

    logic                         cmd_ready_q,   cmd_ready_d;
    logic                         psel_q,        psel_d;
    logic                         penable_q,     penable_d;
    logic                         pwakeup_q,     pwakeup_d;

    logic                         rsp_valid_q,   rsp_valid_d;
    logic [DATA_WIDTH-1:0]        rsp_rdata_q,   rsp_rdata_d;
    logic                         rsp_err_q,     rsp_err_d;
    logic                         rsp_timeout_q, rsp_timeout_d;
    logic [USER_DATA_WIDTH-1:0]   rsp_ruser_q,   rsp_ruser_d;
    logic [USER_RESP_WIDTH-1:0]   rsp_buser_q,   rsp_buser_d;

    assign wait_inc = wait_cnt_q + WAIT_ONE;

    always_comb begin
        state_d       = state_q;
        lead_cnt_d    = lead_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        addr_d        = addr_q;
        prot_d        = prot_q;
        write_d       = write_q;
        wdata_d       = wdata_q;
        strb_d        = strb_q;
        auser_d       = auser_q;
        wuser_d       = wuser_q;
        cmd_ready_d   = cmd_ready_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwakeup_d     = pwakeup_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        rsp_ruser_d   = rsp_ruser_q;
        rsp_buser_d   = rsp_buser_q;

        case (state_q)
            S_IDLE: begin
                cmd_ready_d = 1'b1;
                // cmd_ready is registered, so the first IDLE cycle after reset does not accept.
                if (cmd_valid && cmd_ready_q) begin
                    addr_d      = cmd_addr;
                    prot_d      = cmd_prot;
                    write_d     = cmd_write;
                    wdata_d     = cmd_write ? cmd_wdata : '0;
                    strb_d      = cmd_write ? cmd_strb  : '0;
                    auser_d     = cmd_auser;
                    wuser_d     = cmd_wuser;
                    cmd_ready_d = 1'b0;
                    pwakeup_d   = 1'b1;
                    wait_cnt_d  = '0;
                    lead_cnt_d  = LEAD_ONE;
                    if (WAKEUP_LEAD > 0) begin
                        state_d = S_WAKE;
                    end else begin
                        state_d = S_SETUP;
                        psel_d  = 1'b1;
                    end
                end
            end

            S_WAKE: begin
                if (lead_cnt_q == LEAD_LAST) begin
                    state_d    = S_SETUP;
                    psel_d     = 1'b1;
                    wait_cnt_d = '0;
                end else begin
                    lead_cnt_d = lead_cnt_q + LEAD_ONE;
                end
            end

            S_SETUP: begin
                state_d   = S_ACCESS;
                penable_d = 1'b1;
            end

            S_ACCESS: begin
                // A ready completer always wins over a timeout landing in the same cycle.
                if (pready) begin
                    state_d       = S_RESP;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    pwakeup_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = write_q ? '0 : prdata;
                    rsp_err_d     = pslverr;
                    rsp_timeout_d = 1'b0;
                    rsp_ruser_d   = pruser;
                    rsp_buser_d   = pbuser;
                end else if ((TIMEOUT_CYCLES > 0) && (wait_inc == WAIT_LAST)) begin
                    state_d       = S_RESP;
                    wait_cnt_d    = wait_inc;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    pwakeup_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_ruser_d   = '0;
                    rsp_buser_d   = '0;
                end else if (wait_cnt_q != WAIT_MAX) begin
                    wait_cnt_d = wait_inc;
                end
            end

            S_RESP: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                end
            end

            default: begin
                state_d     = S_IDLE;
                psel_d      = 1'b0;
                penable_d   = 1'b0;
                pwakeup_d   = 1'b0;
                rsp_valid_d = 1'b0;
                cmd_ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q       <= S_IDLE;
            lead_cnt_q    <= '0;
            wait_cnt_q    <= '0;
            addr_q        <= '0;
            prot_q        <= '0;
            write_q       <= 1'b0;
            wdata_q       <= '0;
            strb_q        <= '0;
            auser_q       <= '0;
            wuser_q       <= '0;
            cmd_ready_q   <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwakeup_q     <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_ruser_q   <= '0;
            rsp_buser_q   <= '0;
        end else begin
            state_q       <= state_d;
            lead_cnt_q    <= lead_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            addr_q        <= addr_d;
            prot_q        <= prot_d;
            write_q       <= write_d;
            wdata_q       <= wdata_d;
            strb_q        <= strb_d;
            auser_q       <= auser_d;
            wuser_q       <= wuser_d;
            cmd_ready_q   <= cmd_ready_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwakeup_q     <= pwakeup_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            rsp_ruser_q   <= rsp_ruser_d;
            rsp_buser_q   <= rsp_buser_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign paddr       = addr_q;
    assign pprot       = prot_q;
    assign pwrite      = write_q;
    assign pwdata      = wdata_q;
    assign pstrb       = strb_q;
    assign pauser      = auser_q;
    assign pwuser      = wuser_q;
    assign psel        = psel_q;
    assign penable     = penable_q;
    assign pwakeup     = pwakeup_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;
    assign rsp_ruser   = rsp_ruser_q;
    assign rsp_buser   = rsp_buser_q;

endmodule
`default_nettype wire

// File: tb/tb_apb5_requester.sv
`default_nettype none
// ============================================================================
// tb_apb5_requester: table-driven, hand-written and randomized transfers for
// apb5_requester, checked against a transfer-level model of the APB5 rules.
// Revision: 1.0
// ============================================================================
module tb_apb5_requester;

    localparam int LEAD = 1;
    localparam int TMO  = 4;

    logic        pclk = 1'b0;
    logic        presetn = 1'b1;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_strb;
    logic [2:0]  cmd_prot;
    logic        cmd_auser, cmd_wuser;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err, rsp_timeout, rsp_ruser, rsp_buser;
    logic [31:0] paddr;
    logic [2:0]  pprot;
    logic        psel, penable, pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pwakeup, pauser, pwuser;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr, pruser, pbuser;

    int n_chk  = 0;
    int n_fail = 0;
    int acc[$];

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        logic        auser;
        logic        wuser;
        int          waits;
        logic        slverr;
        logic [31:0] rdata;
        logic        ruser;
        logic        buser;
        int          hold;
        logic [31:0] e_rdata;
        logic        e_err;
        logic        e_to;
        logic        e_ruser;
        logic        e_buser;
    } vec_t;

    vec_t tbl [6];

    apb5_requester #(
        .ADDR_WIDTH      (32),
        .DATA_WIDTH      (32),
        .USER_REQ_WIDTH  (1),
        .USER_DATA_WIDTH (1),
        .USER_RESP_WIDTH (1),
        .WAKEUP_LEAD     (LEAD),
        .TIMEOUT_CYCLES  (TMO)
    ) dut (
        .pclk        (pclk),
        .presetn     (presetn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_strb    (cmd_strb),
        .cmd_prot    (cmd_prot),
        .cmd_auser   (cmd_auser),
        .cmd_wuser   (cmd_wuser),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .rsp_ruser   (rsp_ruser),
        .rsp_buser   (rsp_buser),
        .paddr       (paddr),
        .pprot       (pprot),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .pwdata      (pwdata),
        .pstrb       (pstrb),
        .pwakeup     (pwakeup),
        .pauser      (pauser),
        .pwuser      (pwuser),
        .pready      (pready),
        .prdata      (prdata),
        .pslverr     (pslverr),
        .pruser      (pruser),
        .pbuser      (pbuser)
    );

    always #5 pclk = ~pclk;

    function automatic void chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b, expected %0b (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Transfer-level outcome: an abort happens when the completer needs at
    // least TMO wait states; otherwise the completer's answer is returned.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        logic ab;
        r  = v;
        ab = (v.waits >= TMO);
        r.e_to    = ab;
        r.e_err   = ab || v.slverr;
        r.e_rdata = (ab || v.write) ? 32'h0 : v.rdata;
        r.e_ruser = ab ? 1'b0 : v.ruser;
        r.e_buser = ab ? 1'b0 : v.buser;
        return r;
    endfunction

    task automatic junk_cmd();
        cmd_valid = 1'b1;
        cmd_write = 1'($urandom);
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
        cmd_strb  = 4'($urandom);
        cmd_prot  = 3'($urandom);
        cmd_auser = 1'($urandom);
        cmd_wuser = 1'($urandom);
    endtask

    task automatic junk_apb();
        pready  = 1'($urandom);
        prdata  = $urandom;
        pslverr = 1'($urandom);
        pruser  = 1'($urandom);
        pbuser  = 1'($urandom);
    endtask

    task automatic check_req(input vec_t v, input string ph);
        chk32({ph, "_paddr"},  paddr, v.addr);
        chk1 ({ph, "_pwrite"}, pwrite, v.write);
        chk32({ph, "_pprot"},  {29'h0, pprot}, {29'h0, v.prot});
        chk32({ph, "_pwdata"}, pwdata, v.write ? v.wdata : 32'h0);
        chk32({ph, "_pstrb"},  {28'h0, pstrb}, v.write ? {28'h0, v.strb} : 32'h0);
        chk1 ({ph, "_pauser"}, pauser, v.auser);
        chk1 ({ph, "_pwuser"}, pwuser, v.wuser);
    endtask

    task automatic check_rsp(input vec_t v);
        chk1 ("resp_psel",    psel, 1'b0);
        chk1 ("resp_penable", penable, 1'b0);
        chk1 ("resp_pwakeup", pwakeup, 1'b0);
        chk1 ("resp_cmd_ready", cmd_ready, 1'b0);
        chk1 ("rsp_valid",    rsp_valid, 1'b1);
        chk32("rsp_rdata",    rsp_rdata, v.e_rdata);
        chk1 ("rsp_err",      rsp_err, v.e_err);
        chk1 ("rsp_timeout",  rsp_timeout, v.e_to);
        chk1 ("rsp_ruser",    rsp_ruser, v.e_ruser);
        chk1 ("rsp_buser",    rsp_buser, v.e_buser);
    endtask

    // Entered and left on a falling edge; the completer answers after v.waits
    // wait states and the response is held off for v.hold cycles.
    task automatic run_xfer(input vec_t v);
        int guard;
        int n_acc;
        n_acc     = (v.waits >= TMO) ? TMO : v.waits + 1;
        cmd_valid = 1'b1;
        cmd_write = v.write;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        cmd_strb  = v.strb;
        cmd_prot  = v.prot;
        cmd_auser = v.auser;
        cmd_wuser = v.wuser;
        guard = 0;
        while (!cmd_ready && guard < 16) begin
            @(negedge pclk);
            guard++;
        end
        chk1("cmd_ready_wait", cmd_ready, 1'b1);
        if (!cmd_ready) begin
            cmd_valid = 1'b0;
            return;
        end
        @(negedge pclk);
        for (int i = 0; i < LEAD; i++) begin
            chk1("wake_psel", psel, 1'b0);
            chk1("wake_pwakeup", pwakeup, 1'b1);
            chk1("wake_cmd_ready", cmd_ready, 1'b0);
            junk_cmd();
            junk_apb();
            @(negedge pclk);
        end
        chk1("setup_psel", psel, 1'b1);
        chk1("setup_penable", penable, 1'b0);
        chk1("setup_pwakeup", pwakeup, 1'b1);
        check_req(v, "setup");
        junk_cmd();
        junk_apb();
        @(negedge pclk);
        for (int k = 0; k < n_acc; k++) begin
            chk1("access_psel", psel, 1'b1);
            chk1("access_penable", penable, 1'b1);
            chk1("access_pwakeup", pwakeup, 1'b1);
            chk1("access_rsp_valid", rsp_valid, 1'b0);
            check_req(v, "access");
            junk_cmd();
            junk_apb();
            if (k == v.waits) begin
                pready  = 1'b1;
                prdata  = v.rdata;
                pslverr = v.slverr;
                pruser  = v.ruser;
                pbuser  = v.buser;
            end else begin
                pready = 1'b0;
            end
            @(negedge pclk);
        end
        for (int h = 0; h <= v.hold; h++) begin
            check_rsp(v);
            junk_cmd();
            junk_apb();
            rsp_ready = (h == v.hold);
            @(negedge pclk);
        end
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        pready    = 1'b0;
        chk1("post_rsp_valid", rsp_valid, 1'b0);
        chk1("post_cmd_ready", cmd_ready, 1'b1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not reach the end within the time limit");
        $fatal(1);
    end

    initial begin
        //                write  addr          wdata         strb  prot  au wu wt err rdata         ru bu hold  e_rdata      e_err e_to e_ru e_bu
        tbl[0] = '{1'b1, 32'h0000_0010, 32'hA5A5_0001, 4'hF, 3'd0, 1'b0, 1'b0, 0, 1'b0, 32'h1234_5678, 1'b0, 1'b0, 0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 32'h0000_0020, 32'h1111_2222, 4'hF, 3'd2, 1'b1, 1'b1, 3, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0, 0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 32'h0000_0030, 32'hCAFE_0003, 4'h3, 3'd1, 1'b0, 1'b1, 0, 1'b1, 32'h0,         1'b0, 1'b1, 1, 32'h0,         1'b1, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{1'b0, 32'h0000_0040, 32'h0,         4'h0, 3'd7, 1'b1, 1'b0, 4, 1'b1, 32'h55AA_55AA, 1'b1, 1'b1, 0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 32'h0000_0050, 32'h00C0_FFEE, 4'hC, 3'd4, 1'b1, 1'b0, 1, 1'b0, 32'h7777_7777, 1'b1, 1'b1, 5, 32'h0,         1'b0, 1'b0, 1'b1, 1'b1};
        tbl[5] = '{1'b0, 32'h0000_0060, 32'hFFFF_FFFF, 4'hF, 3'd3, 1'b0, 1'b0, 7, 1'b0, 32'h9999_9999, 1'b1, 1'b1, 2, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0};

        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        cmd_strb  = '0;   cmd_prot  = '0;   cmd_auser = 1'b0; cmd_wuser = 1'b0;
        rsp_ready = 1'b0; pready = 1'b0; prdata = '0; pslverr = 1'b0;
        pruser = 1'b0; pbuser = 1'b0;

        #2 presetn = 1'b0;
        repeat (3) @(negedge pclk);
        chk1 ("reset_cmd_ready", cmd_ready, 1'b0);
        chk1 ("reset_psel",      psel, 1'b0);
        chk1 ("reset_penable",   penable, 1'b0);
        chk1 ("reset_pwakeup",   pwakeup, 1'b0);
        chk1 ("reset_rsp_valid", rsp_valid, 1'b0);
        chk32("reset_paddr",     paddr, 32'h0);
        chk32("reset_pstrb",     {28'h0, pstrb}, 32'h0);
        presetn = 1'b1;
        @(negedge pclk);
        chk1("idle_cmd_ready", cmd_ready, 1'b1);

        for (int i = 0; i < 6; i++) run_xfer(tbl[i]);

        // Back-to-back commands with an always-ready completer and consumer.
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h80; cmd_wdata = 32'h1;
        cmd_strb = 4'hF; rsp_ready = 1'b1; pready = 1'b1; pslverr = 1'b0;
        acc.delete();
        for (int c = 0; c < 12; c++) begin
            if (cmd_ready) acc.push_back(c);
            @(negedge pclk);
        end
        cmd_valid = 1'b0;
        if (acc.size() >= 3) begin
            chk32("accept_spacing_0", 32'(acc[1] - acc[0]), 32'(4 + LEAD));
            chk32("accept_spacing_1", 32'(acc[2] - acc[1]), 32'(4 + LEAD));
        end else begin
            chk32("accept_count", 32'(acc.size()), 32'd3);
        end
        for (int g = 0; g < 20 && !cmd_ready; g++) @(negedge pclk);
        chk1("drain_cmd_ready", cmd_ready, 1'b1);
        rsp_ready = 1'b0;
        pready    = 1'b0;

        for (int i = 0; i < 40; i++) begin
            vec_t v;
            v.write  = 1'($urandom);
            v.addr   = $urandom;
            v.wdata  = $urandom;
            v.strb   = 4'($urandom);
            v.prot   = 3'($urandom);
            v.auser  = 1'($urandom);
            v.wuser  = 1'($urandom);
            v.waits  = $urandom_range(0, 6);
            v.slverr = 1'($urandom);
            v.rdata  = $urandom;
            v.ruser  = 1'($urandom);
            v.buser  = 1'($urandom);
            v.hold   = $urandom_range(0, 3);
            run_xfer(model(v));
        end

        // Asynchronous reset in the middle of an ACCESS phase.
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h70; cmd_strb = 4'h0;
        for (int g = 0; g < 16 && !cmd_ready; g++) @(negedge pclk);
        @(negedge pclk);
        cmd_valid = 1'b0;
        pready    = 1'b0;
        repeat (LEAD + 1) @(negedge pclk);
        chk1("pre_reset_penable", penable, 1'b1);
        #2 presetn = 1'b0;
        #1;
        chk1("async_reset_psel",      psel, 1'b0);
        chk1("async_reset_penable",   penable, 1'b0);
        chk1("async_reset_pwakeup",   pwakeup, 1'b0);
        chk1("async_reset_rsp_valid", rsp_valid, 1'b0);
        chk1("async_reset_cmd_ready", cmd_ready, 1'b0);
        @(negedge pclk);
        presetn = 1'b1;
        repeat (2) @(negedge pclk);
        chk1("post_reset_rsp_valid", rsp_valid, 1'b0);
        chk1("post_reset_psel",      psel, 1'b0);
        run_xfer(tbl[1]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/apb5_requester.md
Name: apb5_requester

Overview:
- Parametrised APB5 requester (completer-facing master) that converts a valid/ready command channel into APB5 SETUP/ACCESS transfers and returns results on a valid/ready response channel.
- Generalises the APB5 interface definition:
  - data width is parametrised end to end, including PRDATA;
  - user widths are configurable;
  - adds PWAKEUP lead-time sequencing and a wait-state timeout.
- Sits between an on-chip command source (e.g. AXI-lite/APB bridge front end) and an APB5 completer.

Parameters:
ADDR_WIDTH, 32, PADDR width
DATA_WIDTH, 32, PWDATA/PRDATA width; legal values 8, 16, 32
USER_REQ_WIDTH, 1, PAUSER width
USER_DATA_WIDTH, 1, PWUSER/PRUSER width
USER_RESP_WIDTH, 1, PBUSER width
WAKEUP_LEAD, 1, cycles PWAKEUP is high before PSEL; 0 means PWAKEUP and PSEL rise together
TIMEOUT_CYCLES, 256, ACCESS cycles without PREADY before abort; 0 disables the timeout

Ports:
pclk  in  1  clock
presetn  in  1  asynchronous active-low reset
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when valid&ready
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_WIDTH  address
cmd_wdata  in  DATA_WIDTH  write data
cmd_strb  in  DATA_WIDTH/8  write strobes
cmd_prot  in  3  protection
cmd_auser  in  USER_REQ_WIDTH  request user
cmd_wuser  in  USER_DATA_WIDTH  write-data user
rsp_valid  out  1  response valid
rsp_ready  in  1  response accepted
rsp_rdata  out  DATA_WIDTH  read data (0 for writes)
rsp_err  out  1  PSLVERR or timeout
rsp_timeout  out  1  transfer aborted by timeout
rsp_ruser  out  USER_DATA_WIDTH  PRUSER capture
rsp_buser  out  USER_RESP_WIDTH  PBUSER capture
paddr  out  ADDR_WIDTH  APB address
pprot  out  3  APB protection
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
pwdata  out  DATA_WIDTH  APB write data
pstrb  out  DATA_WIDTH/8  APB strobes
pwakeup  out  1  APB wake-up
pauser  out  USER_REQ_WIDTH  APB request user
pwuser  out  USER_DATA_WIDTH  APB write user
pready  in  1  completer ready
prdata  in  DATA_WIDTH  completer read data
pslverr  in  1  completer error
pruser  in  USER_DATA_WIDTH  completer read user
pbuser  in  USER_RESP_WIDTH  completer response user

Behaviour:
- Reset (presetn low, asynchronous):
  - all outputs 0 and state IDLE;
  - any in-flight transfer is dropped with no response;
  - the command register and counters clear.
- States and transitions:
  - IDLE: cmd_ready=1. On cmd_valid the command is registered. Next state is WAKE if WAKEUP_LEAD>0, else SETUP.
  - WAKE: pwakeup=1, psel=0. A counter runs WAKEUP_LEAD cycles, then SETUP.
  - SETUP: psel=1, penable=0, pwakeup=1, request signals driven from the register. Exactly one cycle, then ACCESS.
  - ACCESS: psel=1, penable=1.
    - If pready=1: capture prdata (reads only; writes return 0), pslverr, pruser, pbuser; go to RESP.
    - Else increment the wait counter. When the count reaches TIMEOUT_CYCLES (TIMEOUT_CYCLES>0): go to RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0, user outputs 0.
  - RESP: psel=penable=pwakeup=0; rsp_valid=1 with fields stable until rsp_ready. rsp_valid&rsp_ready moves to IDLE.
- pready is ignored outside ACCESS.
- Request outputs (paddr, pprot, pwrite, pwdata, pstrb, pauser, pwuser) hold stable from SETUP through the last ACCESS cycle.
- Reads drive pstrb=0 and pwdata=0 regardless of cmd_strb/cmd_wdata.
- cmd_ready is 1 only in IDLE; one outstanding transfer at a time. Minimum command-to-command spacing is 4+WAKEUP_LEAD cycles with zero wait states and rsp_ready tied high.
- Latency, WAKEUP_LEAD=0, zero wait states:
  - command accepted at edge 0;
  - SETUP in cycle 1 and ACCESS in cycle 2;
  - rsp_valid in cycle 3.
- pslverr is sampled only when pready=1 in ACCESS. rsp_timeout=1 implies rsp_err=1.
- If pready=1 arrives in the same cycle the wait count reaches TIMEOUT_CYCLES, pready wins: a normal completion, no timeout.
- The wait counter is log2(TIMEOUT_CYCLES+1) bits wide, clears on SETUP entry and never wraps.

Test Plan:
- Write addr=0x10, wdata=0xA5A5_0001, strb=0xF, LEAD=1, pready high -> pwakeup rises 1 cycle before psel; pstrb=0xF; rsp_valid with rsp_err=0.
- Read addr=0x20, completer returns 0xDEAD_BEEF after 3 wait states with pruser=1 -> rsp_rdata=0xDEAD_BEEF, rsp_ruser=1; pstrb=0 throughout; request signals stable all 5 APB cycles.
- pslverr=1 with pready on write -> rsp_err=1, rsp_timeout=0.
- TIMEOUT_CYCLES=4, pready held low -> after 4 ACCESS cycles psel/penable drop; rsp_err=1, rsp_timeout=1, rsp_rdata=0.
- rsp_ready low 5 cycles with cmd_valid high -> cmd_ready stays 0 and response fields stay stable; the next command is accepted the cycle after the handshake.
- presetn asserted mid-ACCESS -> psel/penable/pwakeup/rsp_valid go to 0 immediately; the first command after reset completes normally.
